mdu_iter: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two source operands read from the register file (rs1/rs2 values) plus the destination index.
- Produces one writeback beat that drives the register file write port: we = result_valid && result_ready, A3 = result_rd, WD3 = result.
- One operation in flight at a time; radix-2, one bit per cycle.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_sign_fix.sv | 33 +++
 rtl/mdu_iter.sv | 178 +++++++++++++++++
 tb/tb_mdu_iter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_XLEN  = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_XLEN) + 1;

  // Most negative dividend; divided by -1 it overflows the signed quotient.
  localparam logic [MDU_XLEN-1:0] DIV_OVF_DIVIDEND = {1'b1, {(MDU_XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // funct3[2] clear selects the multiply family.
  function automatic logic op_is_mul(input mdu_op_e op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result selection for multiply and divide.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  mdu_op_e             op,
  input  logic                sign_diff,
  input  logic                sign_a,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     rem,
  output logic [XLEN-1:0]     res
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem_f;

  // Negate magnitudes where needed, then pick the architectural result.
  always_comb begin
    prod  = sign_diff ? (~acc + (2*XLEN)'(1)) : acc;
    quo   = sign_diff ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_f = sign_a ? (~rem + XLEN'(1)) : rem;
    res   = '0;
    case (op)
      MDU_MUL:                         res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               res = quo;
      default:                         res = rem_f;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit, one operation in flight.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [4:0]       rd_addr,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       result_rd
);

  localparam logic [XLEN-1:0]  OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(XLEN - 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_op_e           op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              sign_diff_q, sign_diff_d;
  logic              sign_a_q, sign_a_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              ready_en_q, ready_en_d;

  mdu_op_e           in_op;
  logic              s1_signed, s2_signed, s1_neg, s2_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic              accept, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN-1:0]   fixed_res;

  // Decode the incoming request: signedness, magnitudes, special cases.
  always_comb begin
    in_op     = mdu_op_e'(funct3);
    s1_signed = (in_op == MDU_MULH) || (in_op == MDU_MULHSU) ||
                (in_op == MDU_DIV)  || (in_op == MDU_REM);
    s2_signed = (in_op == MDU_MULH) || (in_op == MDU_DIV) || (in_op == MDU_REM);
    s1_neg    = s1_signed && rs1_val[XLEN-1];
    s2_neg    = s2_signed && rs2_val[XLEN-1];
    mag1      = s1_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
    mag2      = s2_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
    div_zero  = !op_is_mul(in_op) && (rs2_val == '0);
    div_ovf   = ((in_op == MDU_DIV) || (in_op == MDU_REM)) &&
                (rs1_val == OVF_DIVIDEND) && (rs2_val == '1);
  end

  // One iteration step: acc holds {partial, multiplier} for multiply and
  // {remainder, dividend/quotient} for restoring division.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    if (op_is_mul(op_q))
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_trial[XLEN+1])
      step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step_acc = {acc_q[2*XLEN-2:0], 1'b0};
  end

  mdu_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .op        (op_q),
    .sign_diff (sign_diff_q),
    .sign_a    (sign_a_q),
    .acc       (step_acc),
    .rem       (step_acc[2*XLEN-1:XLEN]),
    .res       (fixed_res)
  );

  // FSM next state, handshake outputs and datapath register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    sign_diff_d = sign_diff_q;
    sign_a_d    = sign_a_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    res_d       = res_q;
    ready_en_d  = 1'b1;

    start_ready  = ready_en_q && (state_q == IDLE) && !flush;
    accept       = start_valid && start_ready;
    result_valid = (state_q == DONE);

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d        = in_op;
            rd_d        = rd_addr;
            sign_diff_d = s1_neg ^ s2_neg;
            sign_a_d    = s1_neg;
            cnt_d       = '0;
            if (op_is_mul(in_op)) begin
              opnd_d = mag1;
              acc_d  = {{XLEN{1'b0}}, mag2};
            end else begin
              opnd_d = mag2;
              acc_d  = {{XLEN{1'b0}}, mag1};
            end
            if (div_zero) begin
              res_d   = ((in_op == MDU_REM) || (in_op == MDU_REMU)) ? rs1_val : '1;
              state_d = DONE;
            end else if (div_ovf) begin
              res_d   = (in_op == MDU_DIV) ? OVF_DIVIDEND : '0;
              state_d = DONE;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            res_d   = fixed_res;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (result_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= MDU_MUL;
      rd_q        <= '0;
      sign_diff_q <= 1'b0;
      sign_a_q    <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      sign_diff_q <= sign_diff_d;
      sign_a_q    <= sign_a_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign result    = res_q;
  assign result_rd = rd_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table, corner sequences, random ops.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int unsigned XLEN = MDU_XLEN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            start_valid;
  logic            start_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  always #5 clk = ~clk;

  mdu_iter #(
    .XLEN  (XLEN),
    .CNT_W (MDU_CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .rd_addr      (rd_addr),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_rd    (result_rd)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == DIV_OVF_DIVIDEND) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? DIV_OVF_DIVIDEND : 32'(int'(a) / int'(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges after the accept edge until result_valid is seen:
  // XLEN for iterated ops, 0 (valid in the very next cycle) for special cases.
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 0;
    if (((f3 == 3'd4) || (f3 == 3'd6)) && (a == DIV_OVF_DIVIDEND) && (b == 32'hFFFF_FFFF))
      return 0;
    return XLEN;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, scramble the inputs after the accept edge, and wait
  // (bounded) for result_valid. Leaves time in the first valid cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    funct3      = f3;
    rs1_val     = a;
    rs2_val     = b;
    rd_addr     = rd;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    funct3      = 3'($urandom);
    rs1_val     = $urandom;
    rs2_val     = $urandom;
    rd_addr     = 5'($urandom);
    lat = 0;
    while (!result_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input int exp_lat);
    int lat;
    check1({name, " start_ready"}, start_ready, 1'b1);
    issue(f3, a, b, rd, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
    check({name, " result_rd"}, 32'(result_rd), 32'(rd));
    tick();
    check1({name, " single beat"}, result_valid, 1'b0);
  endtask

  task automatic watch(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    bit seen;
    int lat;

    vecs.push_back('{"mul 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, XLEN});
    vecs.push_back('{"mulh min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, XLEN});
    vecs.push_back('{"mulhu max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, XLEN});
    vecs.push_back('{"mulhsu -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, XLEN});
    vecs.push_back('{"mulh -7*3",       3'd1, 32'hFFFF_FFF9, 32'd3,         5'd4,  32'hFFFF_FFFF, XLEN});
    vecs.push_back('{"mul rd0",         3'd0, 32'h1234_5678, 32'd16,        5'd0,  32'h2345_6780, XLEN});
    vecs.push_back('{"div -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, XLEN});
    vecs.push_back('{"rem -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, XLEN});
    vecs.push_back('{"divu 100/7",      3'd5, 32'd100,       32'd7,         5'd8,  32'd14,        XLEN});
    vecs.push_back('{"remu 100/7",      3'd7, 32'd100,       32'd7,         5'd9,  32'd2,         XLEN});
    vecs.push_back('{"divu max/1",      3'd5, 32'hFFFF_FFFF, 32'd1,         5'd10, 32'hFFFF_FFFF, XLEN});
    vecs.push_back('{"div 5/0",         3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 0});
    vecs.push_back('{"rem 5/0",         3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         0});
    vecs.push_back('{"divu 5/0",        3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0});
    vecs.push_back('{"remu 5/0",        3'd7, 32'd5,         32'd0,         5'd14, 32'd5,         0});
    vecs.push_back('{"div ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0});
    vecs.push_back('{"rem ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0});

    rst_n        = 1'b0;
    flush        = 1'b0;
    start_valid  = 1'b0;
    funct3       = '0;
    rs1_val      = '0;
    rs2_val      = '0;
    rd_addr      = '0;
    result_ready = 1'b1;

    #2;
    check1("reset start_ready", start_ready, 1'b0);
    check1("reset result_valid", result_valid, 1'b0);
    check("reset result", result, 32'd0);
    check("reset result_rd", 32'(result_rd), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check1("post-reset start_ready", start_ready, 1'b1);

    // Directed table with back-to-back issue.
    foreach (vecs[i])
      run_check(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                vecs[i].exp, vecs[i].lat);

    // Backpressure: beat and payload hold while result_ready is low.
    result_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd5, 5'd9, lat);
    check("bp latency", 32'(lat), 32'(XLEN));
    check("bp result", result, 32'd15);
    repeat (10) begin
      tick();
      check1("bp valid held", result_valid, 1'b1);
      check("bp result held", result, 32'd15);
      check("bp rd held", 32'(result_rd), 32'd9);
      check1("bp start_ready low", start_ready, 1'b0);
    end
    result_ready = 1'b1;
    tick();
    check1("bp released valid", result_valid, 1'b0);
    check1("bp released start_ready", start_ready, 1'b1);

    // Flush in BUSY cycle 12 discards the op.
    funct3 = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3; rd_addr = 5'd4;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (12) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check1("flush valid low", result_valid, 1'b0);
    watch(40, seen);
    check1("flush no result", seen, 1'b0);
    check1("flush start_ready", start_ready, 1'b1);

    // Flush concurrent with a request: nothing is accepted.
    funct3 = 3'd4; rs1_val = 32'd5; rs2_val = 32'd0; rd_addr = 5'd3;
    start_valid = 1'b1;
    flush = 1'b1;
    #1;
    check1("flush blocks start_ready", start_ready, 1'b0);
    tick();
    start_valid = 1'b0;
    flush = 1'b0;
    watch(40, seen);
    check1("flush+start no result", seen, 1'b0);

    // Reset mid-BUSY: immediate return to reset values, no result.
    funct3 = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 5'd21;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check1("mid reset valid", result_valid, 1'b0);
    check("mid reset result", result, 32'd0);
    check("mid reset rd", 32'(result_rd), 32'd0);
    check1("mid reset start_ready", start_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    watch(40, seen);
    check1("mid reset no result", seen, 1'b0);
    run_check("divu 9/3 after abort", 3'd5, 32'd9, 32'd3, 5'd7, 32'd3, XLEN);

    // Random operations against the arithmetic model.
    for (int unsigned n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int unsigned sel;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = DIV_OVF_DIVIDEND; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
      else if (sel == 3) b = -32'($urandom_range(1, 20));
      run_check("random", f3, a, b, rd, ref_model(f3, a, b), ref_lat(f3, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
